scr1_ahb_mem_arbiter: RTL and testbench
=======================================

SCR1_AHB_MEM_ARBITER -- requirements
Module: scr1_ahb_mem_arbiter

Interface
REQ-001 SHALL have parameter SCR1_AHB_WIDTH, default 32, bus width of address and data.
REQ-002 SHALL have port clk  input  1  single clock; all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have ports imem_htrans input 2, imem_haddr input 32, imem_hsize input 3: imem master address phase.
REQ-005 SHALL have ports imem_hready output 1, imem_hrdata output 32, imem_hresp output 1: imem master response.
REQ-006 SHALL have ports dmem_htrans input 2, dmem_haddr input 32, dmem_hsize input 3, dmem_hwrite input 1, dmem_hwdata input 32: dmem master.
REQ-007 SHALL have ports dmem_hready output 1, dmem_hrdata output 32, dmem_hresp output 1: dmem master response.
REQ-008 SHALL have ports s_htrans output 2, s_haddr output 32, s_hsize output 3, s_hwrite output 1, s_hwdata output 32: shared memory slave.
REQ-009 SHALL have ports s_hready input 1, s_hrdata input 32, s_hresp input 1: shared slave response.

Function
REQ-010 SHALL share one AHB-Lite slave between imem (read-only) and dmem masters; only single transfers; SEQ treated as NONSEQ.
REQ-011 Master request SHALL be accepted from a master on a rising edge where mX_hready=1 and mX_htrans[1]=1.
REQ-012 Per master SHALL keep one hold register (valid, addr, size, write; imem write=0).
REQ-013 Accepted request not issued to slave in the same edge SHALL load the hold register, valid=1.
REQ-014 Request of a master SHALL be pending if hold valid=1, else live htrans[1]=1 with mX_hready=1.
REQ-015 Grant SHALL be round-robin: single pending master wins; both pending -> master not in last_gnt; last_gnt updated on every issue.
REQ-016 Slave address phase SHALL be driven from the granted master's hold register if valid, else its live inputs; s_htrans=2'b10 when a grant exists, 2'b00 otherwise.
REQ-017 A transfer SHALL be issued on an edge with s_htrans=2'b10 and s_hready=1; issuing from hold clears hold valid.
REQ-018 Data-phase owner register (NONE/IMEM/DMEM) SHALL load granted master on issue, NONE on s_hready=1 without issue, hold while s_hready=0.
REQ-019 mX_hready SHALL be s_hready when owner=X; 0 when hold of X valid and owner!=X; 1 otherwise.
REQ-020 mX_hresp SHALL be s_hresp when owner=X, else 0; both hrdata outputs SHALL equal s_hrdata.
REQ-021 s_hwdata SHALL equal dmem_hwdata when owner=DMEM and owner write=1, else 0.
REQ-022 Uncontended request SHALL add zero cycles latency (combinational address path).
REQ-023 Losing request SHALL issue on the first edge after the winner's issue where s_hready=1.
REQ-024 Hold register SHALL never be overwritten while valid (guaranteed by REQ-019 hready=0).
REQ-025 Two-cycle ERROR response (s_hresp=1, s_hready 0 then 1) SHALL pass through to owner only; held request of other master SHALL stay valid and issue after.
REQ-026 s_haddr/s_hsize/s_hwrite SHALL be 0 when s_htrans=2'b00.

Reset
REQ-027 rst_n=0 SHALL asynchronously clear both hold valids, owner=NONE, last_gnt=IMEM (first tie goes to dmem).
REQ-028 During reset outputs SHALL be s_htrans=2'b00, s_haddr/s_hsize/s_hwrite/s_hwdata=0, imem_hready=dmem_hready=1, hresp=0.
REQ-029 Reset mid-transfer SHALL discard held and in-flight transfers with no slave issue after release until a new request.

Verification
REQ-030 imem NONSEQ 0x200 alone, s_hready=1 -> s_haddr=0x200 same cycle, imem_hready=1 next cycle, hrdata routed.
REQ-031 imem 0x200 and dmem write 0x1000 same cycle after reset -> dmem issued first, imem held (imem_hready=0), imem issued next cycle.
REQ-032 dmem write 0x1000 data 0xDEADBEEF, slave 2 wait states -> s_hwdata=0xDEADBEEF throughout, dmem_hready=0 for 2 cycles.
REQ-033 Continuous requests from both for 8 cycles -> strictly alternating grants, 4 issues each.
REQ-034 dmem ERROR response while imem held -> dmem_hresp=1 two cycles, imem_hresp=0, imem issues after.
REQ-035 rst_n low while dmem in data phase and imem held -> all outputs at reset values immediately, no issue after release.

Source files
------------

// File: rtl/scr1_ahb_mem_arbiter.sv
// Two-master AHB-Lite arbiter sharing one memory slave.
// Round-robin grant, one-deep hold per master, zero-latency pass.
module scr1_ahb_mem_arbiter #(
  parameter int SCR1_AHB_WIDTH = 32
) (
  input  logic                      clk,
  input  logic                      rst_n,

  input  logic [1:0]                imem_htrans,
  input  logic [SCR1_AHB_WIDTH-1:0] imem_haddr,
  input  logic [2:0]                imem_hsize,
  output logic                      imem_hready,
  output logic [SCR1_AHB_WIDTH-1:0] imem_hrdata,
  output logic                      imem_hresp,

  input  logic [1:0]                dmem_htrans,
  input  logic [SCR1_AHB_WIDTH-1:0] dmem_haddr,
  input  logic [2:0]                dmem_hsize,
  input  logic                      dmem_hwrite,
  input  logic [SCR1_AHB_WIDTH-1:0] dmem_hwdata,
  output logic                      dmem_hready,
  output logic [SCR1_AHB_WIDTH-1:0] dmem_hrdata,
  output logic                      dmem_hresp,

  output logic [1:0]                s_htrans,
  output logic [SCR1_AHB_WIDTH-1:0] s_haddr,
  output logic [2:0]                s_hsize,
  output logic                      s_hwrite,
  output logic [SCR1_AHB_WIDTH-1:0] s_hwdata,
  input  logic                      s_hready,
  input  logic [SCR1_AHB_WIDTH-1:0] s_hrdata,
  input  logic                      s_hresp
);

  localparam int W = SCR1_AHB_WIDTH;

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_IMEM = 2'd1,
    OWN_DMEM = 2'd2
  } owner_e;

  // imem hold register
  logic         ihold_v_q;
  logic         ihold_v_d;
  logic [W-1:0] ihold_addr_q;
  logic [W-1:0] ihold_addr_d;
  logic [2:0]   ihold_size_q;
  logic [2:0]   ihold_size_d;

  // dmem hold register
  logic         dhold_v_q;
  logic         dhold_v_d;
  logic [W-1:0] dhold_addr_q;
  logic [W-1:0] dhold_addr_d;
  logic [2:0]   dhold_size_q;
  logic [2:0]   dhold_size_d;
  logic         dhold_wr_q;
  logic         dhold_wr_d;

  // data-phase owner and arbitration history
  owner_e       owner_q;
  owner_e       owner_d;
  logic         owner_wr_q;
  logic         owner_wr_d;
  logic         last_dmem_q;
  logic         last_dmem_d;

  logic         imem_acc;
  logic         dmem_acc;
  logic         ipend;
  logic         dpend;
  logic         gnt_i;
  logic         gnt_d;
  logic         issue;

  logic [W-1:0] i_addr;
  logic [2:0]   i_size;
  logic [W-1:0] d_addr;
  logic [2:0]   d_size;
  logic         d_wr;

  // the low htrans bit only distinguishes SEQ from NONSEQ
  logic         unused_htrans;
  assign unused_htrans = imem_htrans[0] ^ dmem_htrans[0];

  // per-master ready: stall while a held request waits its turn
  always_comb begin
    imem_hready = 1'b1;
    dmem_hready = 1'b1;
    if (owner_q == OWN_IMEM) begin
      imem_hready = s_hready;
    end else if (ihold_v_q) begin
      imem_hready = 1'b0;
    end
    if (owner_q == OWN_DMEM) begin
      dmem_hready = s_hready;
    end else if (dhold_v_q) begin
      dmem_hready = 1'b0;
    end
  end

  assign imem_acc = imem_hready & imem_htrans[1];
  assign dmem_acc = dmem_hready & dmem_htrans[1];

  assign ipend = rst_n & (ihold_v_q | imem_acc);
  assign dpend = rst_n & (dhold_v_q | dmem_acc);

  // round-robin: on a tie the master not granted last time wins
  always_comb begin
    gnt_i = 1'b0;
    gnt_d = 1'b0;
    unique case (1'b1)
      ipend & dpend: begin
        gnt_i = last_dmem_q;
        gnt_d = ~last_dmem_q;
      end
      ipend & ~dpend: gnt_i = 1'b1;
      ~ipend & dpend: gnt_d = 1'b1;
      default: ;
    endcase
  end

  assign issue = (gnt_i | gnt_d) & s_hready;

  // address source: held copy first, else the live bus
  always_comb begin
    i_addr = ihold_v_q ? ihold_addr_q : imem_haddr;
    i_size = ihold_v_q ? ihold_size_q : imem_hsize;
    d_addr = dhold_v_q ? dhold_addr_q : dmem_haddr;
    d_size = dhold_v_q ? dhold_size_q : dmem_hsize;
    d_wr   = dhold_v_q ? dhold_wr_q   : dmem_hwrite;
  end

  // slave address phase, zeroed when idle
  always_comb begin
    s_htrans = 2'b00;
    s_haddr  = '0;
    s_hsize  = '0;
    s_hwrite = 1'b0;
    if (gnt_i) begin
      s_htrans = 2'b10;
      s_haddr  = i_addr;
      s_hsize  = i_size;
    end else if (gnt_d) begin
      s_htrans = 2'b10;
      s_haddr  = d_addr;
      s_hsize  = d_size;
      s_hwrite = d_wr;
    end
  end

  // data phase routing by owner
  always_comb begin
    imem_hrdata = s_hrdata;
    dmem_hrdata = s_hrdata;
    imem_hresp  = (owner_q == OWN_IMEM) & s_hresp;
    dmem_hresp  = (owner_q == OWN_DMEM) & s_hresp;
    s_hwdata    = '0;
    if ((owner_q == OWN_DMEM) && owner_wr_q) begin
      s_hwdata = dmem_hwdata;
    end
  end

  // hold a request that was accepted but lost arbitration
  always_comb begin
    ihold_v_d    = ihold_v_q;
    ihold_addr_d = ihold_addr_q;
    ihold_size_d = ihold_size_q;
    dhold_v_d    = dhold_v_q;
    dhold_addr_d = dhold_addr_q;
    dhold_size_d = dhold_size_q;
    dhold_wr_d   = dhold_wr_q;
    if (issue & gnt_i) begin
      ihold_v_d = 1'b0;
    end else if (imem_acc) begin
      ihold_v_d    = 1'b1;
      ihold_addr_d = imem_haddr;
      ihold_size_d = imem_hsize;
    end
    if (issue & gnt_d) begin
      dhold_v_d = 1'b0;
    end else if (dmem_acc) begin
      dhold_v_d    = 1'b1;
      dhold_addr_d = dmem_haddr;
      dhold_size_d = dmem_hsize;
      dhold_wr_d   = dmem_hwrite;
    end
  end

  // owner advances only when the slave completes a phase
  always_comb begin
    owner_d     = owner_q;
    owner_wr_d  = owner_wr_q;
    last_dmem_d = last_dmem_q;
    if (s_hready) begin
      owner_d    = OWN_NONE;
      owner_wr_d = 1'b0;
      if (issue) begin
        owner_d    = gnt_i ? OWN_IMEM : OWN_DMEM;
        owner_wr_d = s_hwrite;
      end
    end
    if (issue) begin
      last_dmem_d = gnt_d;
    end
  end

  // state registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ihold_v_q    <= 1'b0;
      ihold_addr_q <= '0;
      ihold_size_q <= '0;
      dhold_v_q    <= 1'b0;
      dhold_addr_q <= '0;
      dhold_size_q <= '0;
      dhold_wr_q   <= 1'b0;
      owner_q      <= OWN_NONE;
      owner_wr_q   <= 1'b0;
      last_dmem_q  <= 1'b0;
    end else begin
      ihold_v_q    <= ihold_v_d;
      ihold_addr_q <= ihold_addr_d;
      ihold_size_q <= ihold_size_d;
      dhold_v_q    <= dhold_v_d;
      dhold_addr_q <= dhold_addr_d;
      dhold_size_q <= dhold_size_d;
      dhold_wr_q   <= dhold_wr_d;
      owner_q      <= owner_d;
      owner_wr_q   <= owner_wr_d;
      last_dmem_q  <= last_dmem_d;
    end
  end

endmodule

// File: tb/tb_scr1_ahb_mem_arbiter.sv
// Bench for scr1_ahb_mem_arbiter: request-level model checked
// every cycle, plus directed scenarios with literal expectations.
module tb_scr1_ahb_mem_arbiter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  imem_htrans;
  logic [31:0] imem_haddr;
  logic [2:0]  imem_hsize;
  logic        imem_hready;
  logic [31:0] imem_hrdata;
  logic        imem_hresp;
  logic [1:0]  dmem_htrans;
  logic [31:0] dmem_haddr;
  logic [2:0]  dmem_hsize;
  logic        dmem_hwrite;
  logic [31:0] dmem_hwdata;
  logic        dmem_hready;
  logic [31:0] dmem_hrdata;
  logic        dmem_hresp;
  logic [1:0]  s_htrans;
  logic [31:0] s_haddr;
  logic [2:0]  s_hsize;
  logic        s_hwrite;
  logic [31:0] s_hwdata;
  logic        s_hready;
  logic [31:0] s_hrdata;
  logic        s_hresp;

  int n_chk  = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  scr1_ahb_mem_arbiter #(.SCR1_AHB_WIDTH(32)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .imem_htrans (imem_htrans),
    .imem_haddr  (imem_haddr),
    .imem_hsize  (imem_hsize),
    .imem_hready (imem_hready),
    .imem_hrdata (imem_hrdata),
    .imem_hresp  (imem_hresp),
    .dmem_htrans (dmem_htrans),
    .dmem_haddr  (dmem_haddr),
    .dmem_hsize  (dmem_hsize),
    .dmem_hwrite (dmem_hwrite),
    .dmem_hwdata (dmem_hwdata),
    .dmem_hready (dmem_hready),
    .dmem_hrdata (dmem_hrdata),
    .dmem_hresp  (dmem_hresp),
    .s_htrans    (s_htrans),
    .s_haddr     (s_haddr),
    .s_hsize     (s_hsize),
    .s_hwrite    (s_hwrite),
    .s_hwdata    (s_hwdata),
    .s_hready    (s_hready),
    .s_hrdata    (s_hrdata),
    .s_hresp     (s_hresp)
  );

  task automatic chk(input string n, input logic [31:0] a,
                     input logic [31:0] x);
    n_chk++;
    if (a !== x) begin
      n_fail++;
      $display("FAIL %s at %0t: got %h expected %h", n, $time, a, x);
    end
  endtask

  // ---------------- request-level model ----------------
  typedef struct packed {
    logic        v;
    logic [31:0] a;
    logic [2:0]  sz;
    logic        w;
  } req_t;

  typedef struct {
    logic [1:0]  ht;
    logic [31:0] ha;
    logic [2:0]  hs;
    logic        hw;
    logic [31:0] hwd;
    logic [1:0]  hr;
    logic [1:0]  he;
    logic [1:0]  acc;
    int          win;
    logic        issue;
    logic        wr;
  } exp_t;

  // master 0 = imem, master 1 = dmem; own = -1 means no data phase
  req_t held[2] = '{default: '0};
  int   own     = -1;
  logic own_w   = 1'b0;
  int   last    = 0;
  exp_t eu;
  exp_t ec;

  function automatic req_t live(input int m);
    req_t r;
    if (m == 0) r = '{v: imem_htrans[1], a: imem_haddr,
                      sz: imem_hsize, w: 1'b0};
    else        r = '{v: dmem_htrans[1], a: dmem_haddr,
                      sz: dmem_hsize, w: dmem_hwrite};
    return r;
  endfunction

  function automatic exp_t model();
    exp_t e;
    req_t c[2];
    for (int m = 0; m < 2; m++) begin
      req_t l;
      l = live(m);
      if (own == m)        e.hr[m] = s_hready;
      else if (held[m].v)  e.hr[m] = 1'b0;
      else                 e.hr[m] = 1'b1;
      e.acc[m] = l.v & e.hr[m];
      c[m] = held[m].v ? held[m] : l;
      c[m].v = rst_n & (held[m].v | e.acc[m]);
      e.he[m] = (own == m) ? s_hresp : 1'b0;
    end
    e.win = -1;
    if (c[0].v && c[1].v) e.win = 1 - last;
    else if (c[0].v)      e.win = 0;
    else if (c[1].v)      e.win = 1;
    e.ht = 2'b00; e.ha = '0; e.hs = '0; e.hw = 1'b0; e.wr = 1'b0;
    if (e.win >= 0) begin
      e.ht = 2'b10;
      e.ha = c[e.win].a;
      e.hs = c[e.win].sz;
      e.hw = c[e.win].w;
      e.wr = c[e.win].w;
    end
    e.issue = (e.win >= 0) && s_hready;
    e.hwd = (own == 1 && own_w) ? dmem_hwdata : 32'h0;
    return e;
  endfunction

  // model state advance
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      held[0] <= '0;
      held[1] <= '0;
      own     <= -1;
      own_w   <= 1'b0;
      last    <= 0;
    end else begin
      eu = model();
      for (int m = 0; m < 2; m++) begin
        if (eu.issue && eu.win == m) held[m].v <= 1'b0;
        else if (eu.acc[m])          held[m]   <= live(m);
      end
      if (s_hready) begin
        own   <= eu.issue ? eu.win : -1;
        own_w <= eu.issue && eu.wr;
      end
      if (eu.issue) last <= eu.win;
    end
  end

  // per-cycle compare against the model
  always @(negedge clk) begin
    ec = model();
    chk("m_s_htrans",    {30'd0, s_htrans},    {30'd0, ec.ht});
    chk("m_s_haddr",     s_haddr,              ec.ha);
    chk("m_s_hsize",     {29'd0, s_hsize},     {29'd0, ec.hs});
    chk("m_s_hwrite",    {31'd0, s_hwrite},    {31'd0, ec.hw});
    chk("m_s_hwdata",    s_hwdata,             ec.hwd);
    chk("m_imem_hready", {31'd0, imem_hready}, {31'd0, ec.hr[0]});
    chk("m_dmem_hready", {31'd0, dmem_hready}, {31'd0, ec.hr[1]});
    chk("m_imem_hresp",  {31'd0, imem_hresp},  {31'd0, ec.he[0]});
    chk("m_dmem_hresp",  {31'd0, dmem_hresp},  {31'd0, ec.he[1]});
    chk("m_imem_hrdata", imem_hrdata,          s_hrdata);
    chk("m_dmem_hrdata", dmem_hrdata,          s_hrdata);
  end

  // ---------------- directed stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_masters();
    imem_htrans = 2'b00;
    dmem_htrans = 2'b00;
  endtask

  int ni;
  int nd;
  logic [31:0] prev;

  initial begin
    rst_n       = 1'b0;
    imem_htrans = 2'b00;
    imem_haddr  = '0;
    imem_hsize  = 3'd2;
    dmem_htrans = 2'b00;
    dmem_haddr  = '0;
    dmem_hsize  = 3'd2;
    dmem_hwrite = 1'b0;
    dmem_hwdata = '0;
    s_hready    = 1'b1;
    s_hrdata    = '0;
    s_hresp     = 1'b0;

    // reset: a live request must not reach the slave
    step();
    imem_htrans = 2'b10;
    imem_haddr  = 32'h200;
    #1;
    chk("rst_htrans", {30'd0, s_htrans}, 32'd0);
    chk("rst_haddr",  s_haddr, 32'd0);
    chk("rst_ihready", {31'd0, imem_hready}, 32'd1);
    chk("rst_dhready", {31'd0, dmem_hready}, 32'd1);
    imem_htrans = 2'b00;
    step();
    rst_n = 1'b1;

    // lone imem read, zero added latency
    step();
    imem_htrans = 2'b10;
    imem_haddr  = 32'h200;
    #3;
    chk("solo_htrans", {30'd0, s_htrans}, 32'h2);
    chk("solo_haddr",  s_haddr, 32'h200);
    step();
    idle_masters();
    s_hrdata = 32'h1234_5678;
    #3;
    chk("solo_ihready", {31'd0, imem_hready}, 32'd1);
    chk("solo_hrdata",  imem_hrdata, 32'h1234_5678);
    step();

    // simultaneous: dmem first, imem held then issued
    step();
    imem_htrans = 2'b10;
    imem_haddr  = 32'h200;
    dmem_htrans = 2'b10;
    dmem_haddr  = 32'h1000;
    dmem_hwrite = 1'b1;
    #3;
    chk("tie_haddr",  s_haddr, 32'h1000);
    chk("tie_hwrite", {31'd0, s_hwrite}, 32'd1);
    step();
    idle_masters();
    dmem_hwdata = 32'hDEAD_BEEF;
    #3;
    chk("tie_ihready", {31'd0, imem_hready}, 32'd0);
    chk("tie_haddr2",  s_haddr, 32'h200);
    chk("tie_hwdata",  s_hwdata, 32'hDEAD_BEEF);
    step();
    #3;
    chk("tie_ihready2", {31'd0, imem_hready}, 32'd1);
    chk("tie_idle",     {30'd0, s_htrans}, 32'd0);

    // dmem write with two slave wait states
    step();
    dmem_htrans = 2'b10;
    dmem_haddr  = 32'h1000;
    dmem_hwrite = 1'b1;
    dmem_hwdata = 32'h0;
    step();
    idle_masters();
    dmem_hwdata = 32'hDEAD_BEEF;
    s_hready    = 1'b0;
    #3;
    chk("ws_dhready1", {31'd0, dmem_hready}, 32'd0);
    chk("ws_hwdata1",  s_hwdata, 32'hDEAD_BEEF);
    step();
    #3;
    chk("ws_dhready2", {31'd0, dmem_hready}, 32'd0);
    chk("ws_hwdata2",  s_hwdata, 32'hDEAD_BEEF);
    step();
    s_hready = 1'b1;
    #3;
    chk("ws_dhready3", {31'd0, dmem_hready}, 32'd1);
    chk("ws_hwdata3",  s_hwdata, 32'hDEAD_BEEF);
    step();
    dmem_hwrite = 1'b0;
    dmem_hwdata = 32'h0;

    // both masters streaming: grants must alternate
    ni   = 0;
    nd   = 0;
    prev = 32'h0;
    imem_haddr = 32'h300;
    dmem_haddr = 32'h2000;
    for (int i = 0; i < 8; i++) begin
      step();
      imem_htrans = 2'b10;
      dmem_htrans = 2'b10;
      #3;
      if (s_htrans == 2'b10 && s_hready) begin
        chk("rr_alt", {31'd0, s_haddr != prev}, 32'd1);
        prev = s_haddr;
        if (s_haddr == 32'h300)       ni++;
        else if (s_haddr == 32'h2000) nd++;
      end
    end
    chk("rr_imem_cnt", ni, 32'd4);
    chk("rr_dmem_cnt", nd, 32'd4);
    step();
    idle_masters();
    step();

    // dmem ERROR while imem is held
    step();
    imem_htrans = 2'b10;
    imem_haddr  = 32'h204;
    dmem_htrans = 2'b10;
    dmem_haddr  = 32'h1004;
    #3;
    chk("err_first", s_haddr, 32'h1004);
    step();
    idle_masters();
    s_hresp  = 1'b1;
    s_hready = 1'b0;
    #3;
    chk("err_dresp1",  {31'd0, dmem_hresp},  32'd1);
    chk("err_dready1", {31'd0, dmem_hready}, 32'd0);
    chk("err_iresp1",  {31'd0, imem_hresp},  32'd0);
    chk("err_iready1", {31'd0, imem_hready}, 32'd0);
    step();
    s_hready = 1'b1;
    #3;
    chk("err_dresp2",  {31'd0, dmem_hresp},  32'd1);
    chk("err_dready2", {31'd0, dmem_hready}, 32'd1);
    chk("err_iresp2",  {31'd0, imem_hresp},  32'd0);
    chk("err_ihtrans", {30'd0, s_htrans}, 32'h2);
    chk("err_ihaddr",  s_haddr, 32'h204);
    step();
    s_hresp = 1'b0;
    #3;
    chk("err_after", {30'd0, s_htrans}, 32'd0);
    chk("err_iready3", {31'd0, imem_hready}, 32'd1);
    step();

    // reset with dmem in data phase and imem held
    step();
    imem_htrans = 2'b10;
    imem_haddr  = 32'h208;
    dmem_htrans = 2'b10;
    dmem_haddr  = 32'h3000;
    dmem_hwrite = 1'b1;
    step();
    idle_masters();
    dmem_hwdata = 32'hCAFE_F00D;
    s_hready    = 1'b0;
    #1;
    chk("mrst_pre", {31'd0, dmem_hready}, 32'd0);
    rst_n = 1'b0;
    #1;
    chk("mrst_htrans", {30'd0, s_htrans}, 32'd0);
    chk("mrst_haddr",  s_haddr, 32'd0);
    chk("mrst_hwdata", s_hwdata, 32'd0);
    chk("mrst_iready", {31'd0, imem_hready}, 32'd1);
    chk("mrst_dready", {31'd0, dmem_hready}, 32'd1);
    chk("mrst_dresp",  {31'd0, dmem_hresp},  32'd0);
    s_hready = 1'b1;
    step();
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      #3;
      chk("mrst_noissue", {30'd0, s_htrans}, 32'd0);
    end
    step();

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
